// File: rtl/add_sub_pkg.sv
// Shared types for the sequential adder/subtractor: FSM states, op encoding,
// and the chunk-index width helper.
package add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } op_t;

  // A single-chunk datapath still needs a 1-bit index register.
  function automatic int idx_width(input int num_chunks);
    return (num_chunks > 1) ? $clog2(num_chunks) : 1;
  endfunction

endpackage

// File: rtl/add_sub_seq_if.sv
// Operand/result bus of add_sub_seq. The master supplies operands and takes
// results; the slave (the adder) computes.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both 1. Input side: i_valid/a/b/sub from master, i_ready from slave.
// Output side: o_valid/y/c_out/overflow/zero from slave, o_ready from master.
// A slave never makes ready depend combinationally on valid.
interface add_sub_seq_if #(
  parameter int N = 32
);
  logic         i_valid;
  logic         i_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         sub;
  logic         o_valid;
  logic         o_ready;
  logic [N-1:0] y;
  logic         c_out;
  logic         overflow;
  logic         zero;

  modport master (
    output i_valid, a, b, sub, o_ready,
    input  i_ready, o_valid, y, c_out, overflow, zero
  );

  modport slave (
    input  i_valid, a, b, sub, o_ready,
    output i_ready, o_valid, y, c_out, overflow, zero
  );
endinterface

// File: rtl/add_n.sv
// W-bit ripple-carry adder built from full_adder cells. c_msb is the carry
// into bit W-1, needed for signed-overflow detection.
module add_n #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic [W-1:0] y,
  output logic         c_out,
  output logic         c_msb
);
  logic [W:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .c_in (c[i]),
      .s    (y[i]),
      .c_out(c[i+1])
    );
  end

  assign c_out = c[W];
  assign c_msb = c[W-1];
endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);
  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

// File: rtl/add_sub_seq.sv
// Sequential N-bit adder/subtractor: sums CHUNK bits per cycle through one
// add_n slice, delivering the result N/CHUNK cycles after acceptance.
module add_sub_seq
  import add_sub_pkg::*;
#(
  parameter int N     = 32,
  parameter int CHUNK = 8
) (
  input  logic   clk,
  input  logic   rst,
  add_sub_seq_if.slave bus,
  output state_t dbg_state
);
  localparam int NUM = (CHUNK > 0) ? N / CHUNK : 1;
  localparam int IW  = idx_width(NUM);

  if (CHUNK < 1 || CHUNK > N || (N % CHUNK) != 0) begin : g_bad_chunk
    $error("add_sub_seq: CHUNK must divide N and satisfy 1 <= CHUNK <= N");
  end

  state_t        state;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [N-1:0]  res;
  logic [N-1:0]  res_next;
  logic          carry;
  logic [IW-1:0] idx;
  logic          i_ready_q;
  logic          o_valid_q;
  logic          c_out_q;
  logic          ovf_q;
  logic          zero_q;

  op_t            op;
  int             base;
  logic           last;
  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic [CHUNK-1:0] chunk_sum;
  logic           chunk_co;
  logic           chunk_cmsb;

  assign op   = op_t'(bus.sub);
  assign base = int'(idx) * CHUNK;
  assign last = (idx == IW'(NUM - 1));

  always_comb begin
    chunk_a = a_q[base +: CHUNK];
    chunk_b = b_q[base +: CHUNK];
  end

  add_n #(.W(CHUNK)) u_add (
    .a    (chunk_a),
    .b    (chunk_b),
    .c_in (carry),
    .y    (chunk_sum),
    .c_out(chunk_co),
    .c_msb(chunk_cmsb)
  );

  // Zero flag is taken from the result as it will look after the final slice lands.
  always_comb begin
    res_next = res;
    res_next[base +: CHUNK] = chunk_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      res       <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      c_out_q   <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b1;
      o_valid_q <= 1'b0;
      i_ready_q <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_valid && i_ready_q) begin
            // Subtraction is A + ~B + 1: invert B here, seed the carry with 1.
            a_q       <= bus.a;
            b_q       <= bus.b ^ {N{op == SUB}};
            carry     <= (op == SUB);
            idx       <= '0;
            state     <= BUSY;
            i_ready_q <= 1'b0;
          end
        end
        BUSY: begin
          res   <= res_next;
          carry <= chunk_co;
          if (last) begin
            c_out_q   <= chunk_co;
            ovf_q     <= chunk_cmsb ^ chunk_co;
            zero_q    <= (res_next == '0);
            state     <= DONE;
            o_valid_q <= 1'b1;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (bus.o_ready) begin
            state     <= IDLE;
            o_valid_q <= 1'b0;
            i_ready_q <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          o_valid_q <= 1'b0;
          i_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.i_ready  = i_ready_q;
  assign bus.o_valid  = o_valid_q;
  assign bus.y        = res;
  assign bus.c_out    = c_out_q;
  assign bus.overflow = ovf_q;
  assign bus.zero     = zero_q;
  assign dbg_state    = state;
endmodule

// File: tb/tb_add_sub_seq.sv
// Bench for add_sub_seq: directed corner cases on N=32/CHUNK=8 and random
// ADD/SUB streams on three geometries against an arithmetic reference model.
module tb_add_sub_seq;
  import add_sub_pkg::*;

  logic   clk;
  logic   rst;
  state_t dbg0, dbg1, dbg2;
  int     n_cmp;
  int     n_fail;

  add_sub_seq_if #(.N(32)) bus0();
  add_sub_seq_if #(.N(16)) bus1();
  add_sub_seq_if #(.N(16)) bus2();

  add_sub_seq #(.N(32), .CHUNK(8))  dut0 (.clk(clk), .rst(rst), .bus(bus0.slave), .dbg_state(dbg0));
  add_sub_seq #(.N(16), .CHUNK(16)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave), .dbg_state(dbg1));
  add_sub_seq #(.N(16), .CHUNK(1))  dut2 (.clk(clk), .rst(rst), .bus(bus2.slave), .dbg_state(dbg2));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic void ref_model(input int n, input logic [31:0] a_in, input logic [31:0] b_in,
                                    input logic s, output logic [31:0] y, output logic co,
                                    output logic ovf, output logic z);
    logic [63:0] mask, aa, bb, r;
    logic        sa, sb, sy;
    mask = (64'd1 << n) - 64'd1;
    aa   = {32'd0, a_in} & mask;
    bb   = {32'd0, b_in} & mask;
    if (s) begin
      r  = (aa - bb) & mask;
      co = (aa >= bb);
    end else begin
      r  = (aa + bb) & mask;
      co = ((aa + bb) >> n) != 64'd0;
    end
    sa  = aa[n-1];
    sb  = bb[n-1];
    sy  = r[n-1];
    ovf = s ? ((sa != sb) && (sy != sa)) : ((sa == sb) && (sy != sa));
    y   = r[31:0];
    z   = (r == 64'd0);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input int cfg, input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic ordy);
    case (cfg)
      0: begin bus0.i_valid = v; bus0.a = a;       bus0.b = b;       bus0.sub = s; bus0.o_ready = ordy; end
      1: begin bus1.i_valid = v; bus1.a = a[15:0]; bus1.b = b[15:0]; bus1.sub = s; bus1.o_ready = ordy; end
      default: begin bus2.i_valid = v; bus2.a = a[15:0]; bus2.b = b[15:0]; bus2.sub = s; bus2.o_ready = ordy; end
    endcase
  endtask

  task automatic sample(input int cfg, output logic ir, output logic ov, output logic [31:0] y,
                        output logic co, output logic ovf, output logic z);
    case (cfg)
      0: begin ir = bus0.i_ready; ov = bus0.o_valid; y = bus0.y; co = bus0.c_out; ovf = bus0.overflow; z = bus0.zero; end
      1: begin ir = bus1.i_ready; ov = bus1.o_valid; y = 32'(bus1.y); co = bus1.c_out; ovf = bus1.overflow; z = bus1.zero; end
      default: begin ir = bus2.i_ready; ov = bus2.o_valid; y = 32'(bus2.y); co = bus2.c_out; ovf = bus2.overflow; z = bus2.zero; end
    endcase
  endtask

  // Presents one operation while the DUT is idle and waits (bounded) for o_valid.
  // lat = edges from acceptance to o_valid, or -1 on timeout. o_ready stays low.
  task automatic run_op(input int cfg, input logic [31:0] a, input logic [31:0] b, input logic s,
                        output int lat, output logic [31:0] y, output logic co,
                        output logic ovf, output logic z);
    logic ir, ov;
    drive(cfg, 1'b1, a, b, s, 1'b0);
    @(posedge clk); #1;
    lat = -1;
    for (int k = 1; k <= 64; k++) begin
      // Noise on the input side while busy must be ignored.
      drive(cfg, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
      @(posedge clk); #1;
      sample(cfg, ir, ov, y, co, ovf, z);
      if (ov) begin
        lat = k;
        break;
      end
    end
  endtask

  // Optionally stalls o_ready, then completes the output handshake.
  task automatic finish_op(input int cfg, input int stall, output logic ir_after);
    logic ov, co, ovf, z;
    logic [31:0] y;
    for (int k = 0; k < stall; k++) begin
      drive(cfg, 1'b0, $urandom, $urandom, 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    drive(cfg, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(cfg, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    sample(cfg, ir_after, ov, y, co, ovf, z);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic ir, ov, co, ovf, z;
    logic [31:0] y;
    rst = 1'b1;
    // An operand offered during reset must not be taken.
    for (int c = 0; c < 3; c++) drive(c, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) drive(c, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    rst = 1'b0;
    sample(0, ir, ov, y, co, ovf, z);
    n_cmp++; if (ir !== 1'b1) begin n_fail++; $display("FAIL reset_i_ready: got %b want 1", ir); end
    n_cmp++; if (ov !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid: got %b want 0", ov); end
    n_cmp++; if (y !== 32'd0) begin n_fail++; $display("FAIL reset_y: got %h want 0", y); end
    n_cmp++; if (co !== 1'b0) begin n_fail++; $display("FAIL reset_c_out: got %b want 0", co); end
    n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", ovf); end
    n_cmp++; if (z !== 1'b1) begin n_fail++; $display("FAIL reset_zero: got %b want 1", z); end
    n_cmp++;
    if (dbg0 !== IDLE || dbg1 !== IDLE || dbg2 !== IDLE) begin
      n_fail++; $display("FAIL reset_state: got %0d/%0d/%0d want IDLE", dbg0, dbg1, dbg2);
    end
  endtask

  task automatic test_directed();
    logic [31:0] va[6], vb[6], vy[6];
    logic        vs[6], vco[6], vovf[6], vz[6];
    logic [31:0] y;
    logic        co, ovf, z, ir;
    int          lat;
    va = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'd5,         32'd0, 32'd0};
    vb = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'd7,         32'd0, 32'd0};
    vs = '{1'b0,          1'b0,          1'b1,          1'b1,          1'b0,  1'b1};
    vy = '{32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 32'd0, 32'd0};
    vco  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vovf = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vz   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      run_op(0, va[i], vb[i], vs[i], lat, y, co, ovf, z);
      n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL dir%0d_latency: got %0d want 4", i, lat); end
      n_cmp++; if (y !== vy[i]) begin n_fail++; $display("FAIL dir%0d_y: got %h want %h", i, y, vy[i]); end
      n_cmp++; if (co !== vco[i]) begin n_fail++; $display("FAIL dir%0d_c_out: got %b want %b", i, co, vco[i]); end
      n_cmp++; if (ovf !== vovf[i]) begin n_fail++; $display("FAIL dir%0d_overflow: got %b want %b", i, ovf, vovf[i]); end
      n_cmp++; if (z !== vz[i]) begin n_fail++; $display("FAIL dir%0d_zero: got %b want %b", i, z, vz[i]); end
      finish_op(0, 0, ir);
      n_cmp++; if (ir !== 1'b1) begin n_fail++; $display("FAIL dir%0d_return_idle: got %b want 1", i, ir); end
    end
  endtask

  task automatic test_hold_in_done();
    logic [31:0] y, y2;
    logic        co, ovf, z, co2, ovf2, z2, ir, ov;
    int          lat, seen;
    run_op(0, 32'h1234_5678, 32'h1111_1111, 1'b0, lat, y, co, ovf, z);
    n_cmp++; if (y !== 32'h2345_6789) begin n_fail++; $display("FAIL hold_y: got %h want 23456789", y); end
    for (int k = 0; k < 3; k++) begin
      drive(0, 1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
      @(posedge clk); #1;
      sample(0, ir, ov, y2, co2, ovf2, z2);
      n_cmp++; if (ir !== 1'b0) begin n_fail++; $display("FAIL hold%0d_i_ready: got %b want 0", k, ir); end
      n_cmp++; if (ov !== 1'b1) begin n_fail++; $display("FAIL hold%0d_o_valid: got %b want 1", k, ov); end
      n_cmp++;
      if ({y2, co2, ovf2, z2} !== {32'h2345_6789, 1'b0, 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL hold%0d_outputs: got %h/%b%b%b want 23456789/000", k, y2, co2, ovf2, z2);
      end
    end
    drive(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    sample(0, ir, ov, y2, co2, ovf2, z2);
    n_cmp++; if (ir !== 1'b1 || ov !== 1'b0) begin n_fail++; $display("FAIL hold_release: got i_ready=%b o_valid=%b want 1/0", ir, ov); end
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (bus0.o_valid !== 1'b0 || dbg0 !== IDLE) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL hold_no_queue: got %0d busy cycles want 0", seen); end
    n_cmp++; if (bus0.y !== 32'h2345_6789) begin n_fail++; $display("FAIL hold_retain_y: got %h want 23456789", bus0.y); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] y;
    logic        co, ovf, z, ir, ov;
    int          lat, seen;
    drive(0, 1'b1, 32'd1, 32'd1, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sample(0, ir, ov, y, co, ovf, z);
    n_cmp++; if (dbg0 !== IDLE) begin n_fail++; $display("FAIL abort_state: got %0d want IDLE", dbg0); end
    n_cmp++; if (ir !== 1'b1 || ov !== 1'b0) begin n_fail++; $display("FAIL abort_handshake: got i_ready=%b o_valid=%b want 1/0", ir, ov); end
    n_cmp++; if (y !== 32'd0 || z !== 1'b1) begin n_fail++; $display("FAIL abort_result: got y=%h zero=%b want 0/1", y, z); end
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (bus0.o_valid !== 1'b0) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL abort_no_result: got %0d valid cycles want 0", seen); end
    // Reset beats a simultaneous output handshake in DONE.
    run_op(0, 32'h8000_0000, 32'h8000_0000, 1'b0, lat, y, co, ovf, z);
    drive(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    sample(0, ir, ov, y, co, ovf, z);
    n_cmp++;
    if ({ir, ov, y, co, ovf, z} !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL abort_done: got ir=%b ov=%b y=%h co=%b ovf=%b z=%b want 1 0 0 0 0 1", ir, ov, y, co, ovf, z);
    end
  endtask

  task automatic test_random(input int cfg, input int n, input int nchunks, input int count);
    logic [31:0] a, b, y, ey;
    logic        s, co, ovf, z, eco, eovf, ez, ir;
    int          lat;
    for (int i = 0; i < count; i++) begin
      a = $urandom;
      b = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0: b = a;
        1: a = 32'hFFFF_FFFF;
        2: b = 32'd1;
        3: a = 32'd1 << (n - 1);
        default: ;
      endcase
      ref_model(n, a, b, s, ey, eco, eovf, ez);
      run_op(cfg, a, b, s, lat, y, co, ovf, z);
      n_cmp++; if (lat !== nchunks) begin n_fail++; $display("FAIL rnd%0d_%0d_latency: got %0d want %0d", cfg, i, lat, nchunks); end
      n_cmp++; if (y !== ey) begin n_fail++; $display("FAIL rnd%0d_%0d_y: a=%h b=%h sub=%b got %h want %h", cfg, i, a, b, s, y, ey); end
      n_cmp++; if (co !== eco) begin n_fail++; $display("FAIL rnd%0d_%0d_c_out: got %b want %b", cfg, i, co, eco); end
      n_cmp++; if (ovf !== eovf) begin n_fail++; $display("FAIL rnd%0d_%0d_overflow: got %b want %b", cfg, i, ovf, eovf); end
      n_cmp++; if (z !== ez) begin n_fail++; $display("FAIL rnd%0d_%0d_zero: got %b want %b", cfg, i, z, ez); end
      finish_op(cfg, $urandom_range(0, 2), ir);
      n_cmp++; if (ir !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_%0d_return_idle: got %b want 1", cfg, i, ir); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    test_reset();
    test_directed();
    test_hold_in_done();
    test_reset_abort();
    test_random(0, 32, 4, 1000);
    test_random(1, 16, 1, 1000);
    test_random(2, 16, 16, 1000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/add_sub_seq.md
ADD_SUB_SEQ -- requirements
Module: add_sub_seq

Interface
REQ-001 SHALL have parameter N, default 32, operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 8, bits summed per cycle; N % CHUNK == 0 and 1 <= CHUNK <= N (elaboration error otherwise).
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_valid  in  1  operands/op present.
REQ-006 SHALL have port i_ready  out  1  block can accept operands.
REQ-007 SHALL have port a  in  N  operand A.
REQ-008 SHALL have port b  in  N  operand B.
REQ-009 SHALL have port sub  in  1  0 = A+B, 1 = A-B.
REQ-010 SHALL have port o_valid  out  1  result valid.
REQ-011 SHALL have port o_ready  in  1  consumer takes result.
REQ-012 SHALL have port y  out  N  sum/difference, modulo 2^N.
REQ-013 SHALL have port c_out  out  1  carry out of bit N-1 (subtract: 1 = no borrow).
REQ-014 SHALL have port overflow  out  1  two's-complement signed overflow.
REQ-015 SHALL have port zero  out  1  y == 0.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-017 SHALL drive i_ready=1 only in IDLE; o_valid=1 only in DONE.
REQ-018 SHALL accept on the rising edge where i_valid & i_ready: latch a, b XOR {N{sub}}, carry register = sub, chunk index = 0; go BUSY.
REQ-019 SHALL, in each BUSY cycle, add chunk [idx*CHUNK +: CHUNK] of latched A and B with the carry register, write the sum into the same slice of the result register, update the carry register, and increment idx.
REQ-020 SHALL, on the BUSY cycle with idx == N/CHUNK-1, capture the carry into bit N-1 and the carry out, then go DONE.
REQ-021 SHALL assert o_valid exactly N/CHUNK cycles after the acceptance edge (e.g. 4 for N=32, CHUNK=8; 1 for CHUNK=N).
REQ-022 SHALL compute overflow = carry into bit N-1 XOR carry out of bit N-1, and zero from the full result register.
REQ-023 SHALL hold y, c_out, overflow and zero stable while in DONE, regardless of inputs.
REQ-024 SHALL return to IDLE on the edge where o_valid & o_ready; outputs retain last values until the next result overwrites them.
REQ-025 SHALL ignore i_valid, a, b and sub while not in IDLE (no queueing, no corruption).
REQ-026 SHALL produce results bit-identical to (a + b) or (a - b) mod 2^N for every N/CHUNK combination.

Reset
REQ-027 SHALL, on any clk edge with rst=1, enter IDLE and clear idx, carry, result, c_out, overflow to 0 and set zero=1, o_valid=0, i_ready=1 from the next cycle.
REQ-028 SHALL abort any BUSY/DONE operation on rst with no result delivered; rst wins over a simultaneous acceptance or o_ready handshake.

Structure
REQ-029 SHALL take the FSM state enum and the op encoding (ADD=0, SUB=1) from shared package add_sub_pkg.
REQ-030 SHALL instantiate one combinational sub-module add_n (parameter W=CHUNK; ports a, b, c_in, y, c_out, c_msb = carry into bit W-1), built from the team's existing full_adder cells.

Verification
REQ-031 SHALL pass: N=32,CHUNK=8, ADD 0xFFFFFFFF+0x00000001 -> o_valid 4 cycles after acceptance, y=0, c_out=1, overflow=0, zero=1.
REQ-032 SHALL pass: ADD 0x7FFFFFFF+0x00000001 -> y=0x80000000, overflow=1, c_out=0; SUB 0x80000000-0x00000001 -> y=0x7FFFFFFF, overflow=1, c_out=1.
REQ-033 SHALL pass: SUB 5-7 -> y=0xFFFFFFFE, c_out=0, overflow=0, zero=0.
REQ-034 SHALL pass: o_ready held low 3 cycles in DONE, i_valid pulsed with new operands -> i_ready=0, outputs unchanged, new operands never consumed; o_ready high -> IDLE next cycle.
REQ-035 SHALL pass: rst asserted on second BUSY cycle -> next cycle IDLE, i_ready=1, o_valid=0, y=0, zero=1; no o_valid follows.
REQ-036 SHALL pass: 1000 random ADD/SUB ops each for (N,CHUNK) = (32,8), (16,16), (16,1) vs. reference model, checking latency N/CHUNK and all four result outputs.
